// File: rtl/alu_result_checker_pkg.sv
// Shared types and constants for the ALU result checker: FSM encoding,
// default datapath width and the MISR feedback polynomial.
package checker_pkg;

  localparam int DATAPATH_DSIZE = 16;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  localparam logic [15:0] SIG_POLY = 16'h1021;

endpackage

// File: rtl/alu_result_checker_gold_ram.sv
// Gold table storage: DEPTH x DSIZE, synchronous write, asynchronous read.
// Contents are deliberately not reset; they are loaded before each run.
module gold_ram #(
  parameter int DSIZE = 16,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [DSIZE-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [DSIZE-1:0] rdata
);

  logic [DSIZE-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/alu_result_checker.sv
// Consumer-side checker comparing the datapath ALUOut stream against a gold table.
// Optional MISR signature output enabled by defining CHECKER_SIGNATURE_EN.
module alu_result_checker
  import checker_pkg::*;
#(
  parameter int DSIZE = DATAPATH_DSIZE,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             gold_we,
  input  logic [AW-1:0]    gold_waddr,
  input  logic [DSIZE-1:0] gold_wdata,
  input  logic [AW:0]      expect_count,
  input  logic             start,
  input  logic             sample_valid,
  input  logic [DSIZE-1:0] alu_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [AW:0]      err_count,
  output logic [AW-1:0]    first_err_idx,
  output logic [DSIZE-1:0] first_err_got,
  output logic [DSIZE-1:0] first_err_exp,
  output logic             extra_sample,
  output logic [1:0]       state_dbg
`ifdef CHECKER_SIGNATURE_EN
  ,
  output logic [DSIZE-1:0] sig
`endif
);

  localparam logic [AW:0] CNT_ONE = (AW+1)'(1);

  state_t           state, state_nx;
  logic [AW:0]      cnt_lim;
  logic [AW-1:0]    idx;
  logic [DSIZE-1:0] gold_rd;
  logic             start_run;
  logic             take;
  logic             mismatch;
  logic             last;

  // Stream contract: sample_valid alone qualifies alu_out; there is no ready.
  // Every valid cycle in RUN is consumed, in order, with no backpressure.
  assign start_run = start && (state != RUN);
  assign take      = sample_valid && (state == RUN);
  assign mismatch  = take && (alu_out != gold_rd);
  assign last      = ({1'b0, idx} == (cnt_lim - CNT_ONE));

  gold_ram #(.DSIZE(DSIZE), .DEPTH(DEPTH), .AW(AW)) u_gold (
    .clk   (clk),
    .we    (gold_we && (state != RUN)),
    .waddr (gold_waddr),
    .wdata (gold_wdata),
    .raddr (idx),
    .rdata (gold_rd)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE, DONE: if (start) state_nx = (expect_count == '0) ? DONE : RUN;
      RUN:        if (take && last) state_nx = DONE;
      default:    state_nx = IDLE;
    endcase
  end

  assign busy      = (state == RUN);
  assign done      = (state == DONE);
  assign pass      = done && (err_count == '0);
  assign state_dbg = state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_lim       <= '0;
      idx           <= '0;
      err_count     <= '0;
      first_err_idx <= '0;
      first_err_got <= '0;
      first_err_exp <= '0;
      extra_sample  <= 1'b0;
    end else if (start_run) begin
      cnt_lim       <= expect_count;
      idx           <= '0;
      err_count     <= '0;
      first_err_idx <= '0;
      first_err_got <= '0;
      first_err_exp <= '0;
      extra_sample  <= 1'b0;
    end else if (take) begin
      idx <= idx + AW'(1);
      if (mismatch) begin
        err_count <= err_count + CNT_ONE;
        if (err_count == '0) begin
          first_err_idx <= idx;
          first_err_got <= alu_out;
          first_err_exp <= gold_rd;
        end
      end
    end else if (done && sample_valid) begin
      extra_sample <= 1'b1;
    end
  end

`ifdef CHECKER_SIGNATURE_EN
  logic [DSIZE-1:0] sig_nx;

  always_comb begin
    sig_nx = {sig[DSIZE-2:0], 1'b0} ^ alu_out;
    if (sig[DSIZE-1]) sig_nx = sig_nx ^ DSIZE'(SIG_POLY);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)           sig <= '0;
    else if (start_run) sig <= '0;
    else if (take)      sig <= sig_nx;
  end
`endif

endmodule

// File: tb/tb_alu_result_checker.sv
// Directed scoreboard bench for alu_result_checker; the signature checks are
// compiled in only when CHECKER_SIGNATURE_EN is defined.
module tb_alu_result_checker;
  import checker_pkg::*;

  localparam int DSIZE = 16;
  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int W     = 1 + (AW + 1) + AW + 2 * DSIZE;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             gold_we = 1'b0;
  logic [AW-1:0]    gold_waddr = '0;
  logic [DSIZE-1:0] gold_wdata = '0;
  logic [AW:0]      expect_count = '0;
  logic             start = 1'b0;
  logic             sample_valid = 1'b0;
  logic [DSIZE-1:0] alu_out = '0;
  logic             busy, done, pass, extra_sample;
  logic [AW:0]      err_count;
  logic [AW-1:0]    first_err_idx;
  logic [DSIZE-1:0] first_err_got, first_err_exp;
  logic [1:0]       state_dbg;
`ifdef CHECKER_SIGNATURE_EN
  logic [DSIZE-1:0] sig;
`endif

  alu_result_checker #(.DSIZE(DSIZE), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk           (clk),
    .rst           (rst),
    .gold_we       (gold_we),
    .gold_waddr    (gold_waddr),
    .gold_wdata    (gold_wdata),
    .expect_count  (expect_count),
    .start         (start),
    .sample_valid  (sample_valid),
    .alu_out       (alu_out),
    .busy          (busy),
    .done          (done),
    .pass          (pass),
    .err_count     (err_count),
    .first_err_idx (first_err_idx),
    .first_err_got (first_err_got),
    .first_err_exp (first_err_exp),
    .extra_sample  (extra_sample),
    .state_dbg     (state_dbg)
`ifdef CHECKER_SIGNATURE_EN
    ,
    .sig           (sig)
`endif
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] mk_exp(input logic p, input logic [AW:0] ec,
                                          input logic [AW-1:0] fi, input logic [DSIZE-1:0] fg,
                                          input logic [DSIZE-1:0] fe);
    return {p, ec, fi, fg, fe};
  endfunction

  // Monitor: a run completes when done rises, or stays high right after a start.
  logic         done_prev = 1'b0;
  logic         start_last = 1'b0;
  logic [W-1:0] mon_e;

  always @(negedge clk) begin
    if (!rst) begin
      done_prev  = 1'b0;
      start_last = 1'b0;
    end else begin
      if (done && (!done_prev || start_last)) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got done=1 expected no run pending (t=%0t)", $time);
        end else begin
          mon_e = exp_q.pop_front();
          check("run_pass",          pass,          mon_e[W-1]);
          check("run_err_count",     err_count,     mon_e[W-2 -: AW+1]);
          check("run_first_err_idx", first_err_idx, mon_e[2*DSIZE+AW-1 -: AW]);
          check("run_first_err_got", first_err_got, mon_e[2*DSIZE-1 -: DSIZE]);
          check("run_first_err_exp", first_err_exp, mon_e[DSIZE-1:0]);
        end
      end
      done_prev  = done;
      start_last = start;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic load_gold(input logic [AW-1:0] a, input logic [DSIZE-1:0] d);
    gold_we = 1'b1; gold_waddr = a; gold_wdata = d;
    cycle();
    gold_we = 1'b0;
  endtask

  task automatic start_run(input logic [AW:0] cnt, input logic [W-1:0] e);
    exp_q.push_back(e);
    expect_count = cnt;
    start = 1'b1;
    cycle();
    start = 1'b0;
    check("busy_after_start", busy, (cnt != 0));
  endtask

  task automatic feed(input logic v, input logic [DSIZE-1:0] d);
    sample_valid = v; alu_out = d;
    cycle();
    sample_valid = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  logic [DSIZE-1:0] gold_vals [4] = '{16'h0001, 16'h0002, 16'h0004, 16'h0008};
  logic [DSIZE-1:0] bad_vals  [4] = '{16'h0001, 16'h0003, 16'h0004, 16'h0009};
  logic             gap_v     [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

  initial begin
    int k;
    repeat (3) cycle();
    check("reset_state", state_dbg, IDLE);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_pass", pass, 0);
    check("reset_err_count", err_count, 0);
    check("reset_extra", extra_sample, 0);
    rst = 1'b1;
    cycle();

    // 1: matching stream, back to back
    for (int i = 0; i < 4; i++) load_gold(AW'(i), gold_vals[i]);
    start_run(5'd4, mk_exp(1'b1, 5'd0, 4'd0, 16'h0000, 16'h0000));
    for (int i = 0; i < 4; i++) begin
      feed(1'b1, gold_vals[i]);
      if (i == 2) check("t1_no_early_done", done, 0);
    end
    check("t1_done", done, 1);

    // 2: two mismatches, first at index 1
    start_run(5'd4, mk_exp(1'b0, 5'd2, 4'd1, 16'h0003, 16'h0002));
    for (int i = 0; i < 4; i++) begin
      feed(1'b1, bad_vals[i]);
      if (i == 1) check("t2_err_latency", err_count, 1);
    end

    // 3: zero-length run
    start_run(5'd0, mk_exp(1'b1, 5'd0, 4'd0, 16'h0000, 16'h0000));
    check("t3_done_next_cycle", done, 1);

    // 4: sample_valid gaps, then a stray sample in DONE
    start_run(5'd4, mk_exp(1'b1, 5'd0, 4'd0, 16'h0000, 16'h0000));
    k = 0;
    for (int i = 0; i < 7; i++) begin
      feed(gap_v[i], gap_v[i] ? gold_vals[k] : 16'hdead);
      if (gap_v[i]) k++;
      if (i == 4) check("t4_no_early_done", done, 0);
    end
    check("t4_extra_before", extra_sample, 0);
    feed(1'b1, 16'h0055);
    check("t4_extra_after", extra_sample, 1);
    check("t4_pass_holds", pass, 1);

    // 5: reset mid-run after a mismatch, then a clean restart
    start_run(5'd4, mk_exp(1'b1, 5'd0, 4'd0, 16'h0000, 16'h0000));
    feed(1'b1, 16'h0001);
    feed(1'b1, 16'h0007);
    check("t5_err_before_reset", err_count, 1);
    exp_q.delete();
    rst = 1'b0;
    #2;
    check("t5_rst_state", state_dbg, IDLE);
    check("t5_rst_busy", busy, 0);
    check("t5_rst_err", err_count, 0);
    check("t5_rst_first_idx", first_err_idx, 0);
    check("t5_rst_first_got", first_err_got, 0);
    check("t5_rst_first_exp", first_err_exp, 0);
    cycle();
    rst = 1'b1;
    cycle();
    start_run(5'd4, mk_exp(1'b1, 5'd0, 4'd0, 16'h0000, 16'h0000));
    load_gold(4'd3, 16'hffff);  // must be ignored while running
    for (int i = 0; i < 4; i++) feed(1'b1, gold_vals[i]);
    check("t5_restart_done", done, 1);

    // 6: gold write in the same cycle as start is seen by the run
    gold_we = 1'b1; gold_waddr = 4'd0; gold_wdata = 16'h1234;
    start_run(5'd1, mk_exp(1'b1, 5'd0, 4'd0, 16'h0000, 16'h0000));
    gold_we = 1'b0;
    feed(1'b1, 16'h1234);

`ifdef CHECKER_SIGNATURE_EN
    load_gold(4'd0, 16'h0001);
    start_run(5'd1, mk_exp(1'b1, 5'd0, 4'd0, 16'h0000, 16'h0000));
    check("sig_cleared", sig, 16'h0000);
    feed(1'b1, 16'h0001);
    check("sig_0001", sig, 16'h0001);
    load_gold(4'd0, 16'h8000);
    load_gold(4'd1, 16'h0000);
    start_run(5'd2, mk_exp(1'b1, 5'd0, 4'd0, 16'h0000, 16'h0000));
    feed(1'b1, 16'h8000);
    check("sig_8000", sig, 16'h8000);
    feed(1'b1, 16'h0000);
    check("sig_poly", sig, 16'h1021);
    feed(1'b1, 16'h00ff);
    check("sig_holds_in_done", sig, 16'h1021);
`endif

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) cycle();
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending runs expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_result_checker.md
# alu_result_checker

Synthesizable consumer-side checker for the datapath: it samples the datapath's ALUOut stream, compares each sample in order against a preloaded table of expected values, and reports the mismatch count plus the first failing sample. It sits on the datapath output, opposite the instruction/stimulus driver. This lets on-chip or FPGA runs self-check without file I/O.

## Interface
Parameters:
- DSIZE, 16, width of ALUOut and of each expected value.
- DEPTH, 16, number of gold entries (power of two).
- AW, $clog2(DEPTH), gold address width.

Ports:
- clk, input, 1, single clock; all state updates on rising edge.
- rst, input, 1, asynchronous active-low reset.
- gold_we, input, 1, write strobe for the gold table; honoured only in IDLE or DONE.
- gold_waddr, input, AW, gold write address.
- gold_wdata, input, DSIZE, expected value to store.
- expect_count, input, AW+1, number of samples to check (0..DEPTH); sampled on start.
- start, input, 1, one-cycle pulse that begins a check run.
- sample_valid, input, 1, alu_out holds a result to check this cycle.
- alu_out, input, DSIZE, datapath ALUOut.
- busy, output, 1, high in RUN.
- done, output, 1, high in DONE.
- pass, output, 1, done && err_count==0.
- err_count, output, AW+1, number of mismatches in current/last run.
- first_err_idx, output, AW, sample index of the first mismatch.
- first_err_got, output, DSIZE, alu_out at first mismatch.
- first_err_exp, output, DSIZE, gold value at first mismatch.
- extra_sample, output, 1, sticky: sample_valid seen in DONE.
- sig, output, DSIZE, MISR signature (only with CHECKER_SIGNATURE_EN).

## Operation
- States: IDLE, RUN, DONE.
- IDLE: gold writes accepted; sample_valid ignored. start -> RUN, latch expect_count into cnt_lim, idx=0, clear err_count, first_err_*, extra_sample, sig.
- start with expect_count==0: go directly to DONE (pass=1).
- RUN: on each sample_valid, compare alu_out with gold[idx] (combinational read). On mismatch, increment err_count; if err_count was 0, capture idx/alu_out/gold into first_err_*. Increment idx. If idx==cnt_lim-1, go to DONE.
- RUN: gold_we is ignored (table is frozen during a run). start is ignored.
- DONE: outputs hold. start -> RUN (re-arm, same clearing as from IDLE). sample_valid sets extra_sample.
- err_count cannot exceed DEPTH, so no saturation is required. Width AW+1 covers the DEPTH==expect_count case.
- If start and gold_we are asserted in the same cycle in IDLE or DONE, the write happens and the run starts. The new value is visible from the first RUN sample.

## Timing
- Reset: state=IDLE; busy, done, pass, extra_sample = 0; err_count, first_err_*, sig = 0. Gold contents are not reset.
- busy rises in the cycle after start.
- Compare latency 1: err_count and first_err_* update on the edge that consumes the sample.
- done rises on the edge that consumes the last sample, so it is visible in the next cycle.
- Back-to-back sample_valid every cycle is supported, with no bubbles.
- Reset assertion mid-run aborts immediately to IDLE with all outputs cleared.

## Configuration
- CHECKER_SIGNATURE_EN defined:
  - sig is present. On every consumed sample: sig <= {sig[DSIZE-2:0],1'b0} ^ (sig[DSIZE-1] ? SIG_POLY : 0) ^ alu_out.
  - sig is cleared on start and holds in DONE.
- CHECKER_SIGNATURE_EN undefined: the sig port and its logic are absent. All other behaviour is identical.

## Structure
- Package checker_pkg:
  - state encoding IDLE=2'b00, RUN=2'b01, DONE=2'b10;
  - SIG_POLY = 16'h1021.
- DSIZE defaults track the shared datapath size defines.
- Sub-module gold_ram: DEPTH x DSIZE, synchronous write, asynchronous read, no reset.

## Test plan
- Load gold 0..3 = 0001,0002,0004,0008; expect_count=4; start; feed the matching stream with sample_valid every cycle -> done one cycle after 4th sample, pass=1, err_count=0.
- Same gold; feed 0001,0003,0004,0009 -> err_count=2, first_err_idx=1, first_err_got=0003, first_err_exp=0002, pass=0.
- expect_count=0; start -> done next cycle, pass=1, busy never high.
- Feed samples with sample_valid gaps (1,0,0,1,1,0,1); 4 valid matching samples -> pass=1, done only after the 4th valid sample. Then one more sample_valid in DONE -> extra_sample=1.
- Mid-run (after 2 samples) drop rst for one cycle -> IDLE, all outputs 0. Restart with the same gold -> clean pass.
- With CHECKER_SIGNATURE_EN: single sample 0001 from sig=0 -> sig=0001. Then sample 8000 -> sig=8000. Then sample 0000 -> sig=1021.
